mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_load_extract.sv | 33 +++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared EXE/MEM/WB bus field positions, widths and exception codes.
// Imported by every stage that packs or unpacks the EXE->MEM->WB buses.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 231;
    localparam int MEM_WB_W  = 223;
    localparam int MEM_ID_W  = 39;

    // EXE->MEM bus layout above the writeback fields
    localparam int MEM_REQ_BIT = 230;
    localparam int VLO_HI      = 229;
    localparam int VLO_LO      = 228;
    localparam int LD_HI       = 227;
    localparam int LD_LO       = 223;

    // one-hot index inside ld_type
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    // writeback field positions
    localparam int GR_WE_BIT = 37;
    localparam int DEST_HI   = 36;
    localparam int DEST_LO   = 32;

    // exception / ertn flag positions
    localparam int EXC_A_HI  = 222;
    localparam int EXC_A_LO  = 217;
    localparam int EXC_B_HI  = 206;
    localparam int EXC_B_LO  = 204;
    localparam int INE_BIT   = 205;
    localparam int ERTN_BIT  = 171;
    localparam int EXC_C_BIT = 88;
    localparam int EXC_D_BIT = 87;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    function automatic logic has_flush(input logic [MEM_WB_W-1:0] wb);
        return (|wb[EXC_A_HI:EXC_A_LO]) | (|wb[EXC_B_HI:EXC_B_LO])
             | wb[ERTN_BIT] | wb[EXC_C_BIT] | wb[EXC_D_BIT];
    endfunction

endpackage

// File: rtl/mem_stage_load_extract.sv
// Load data extraction: byte/halfword select with sign or zero extend.
// Ports: ld_type (one-hot), vaddr_lo, rdata, alu_result in; result out.
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_type,
    input  logic [1:0]  vaddr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] alu_result,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rdata >> {vaddr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = vaddr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = alu_result;
        unique case (1'b1)
            ld_type[LD_B]:  result = {{24{byte_v[7]}}, byte_v};
            ld_type[LD_BU]: result = {24'h0, byte_v};
            ld_type[LD_H]:  result = {{16{half_v[15]}}, half_v};
            ld_type[LD_HU]: result = {16'h0, half_v};
            ld_type[LD_W]:  result = rdata;
            default:        result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for in-order data responses, buffers early ones,
// drops responses belonging to flushed requests, extracts load data.
// Ports: EXE handshake/bus in, data_sram response in, WB handshake/bus
// out, ID bypass bus out, flush hint out to EXE.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         EXE_to_MEM_valid,
    output logic         MEM_allowin,
    input  logic [230:0] EXE_to_MEM_bus,
    input  logic         EXE_req_inflight,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         WB_allowin,
    input  logic         exec_flush,
    output logic         MEM_to_WB_valid,
    output logic [222:0] MEM_to_WB_bus,
    output logic [38:0]  MEM_to_ID_bus,
    output logic         MEM_flush_hint
);

    localparam logic [CANCEL_W:0] CNT_MAX = (CANCEL_W+1)'(2);

    logic                MEM_valid;
    logic [230:0]        bus_r;
    logic                buf_valid;
    logic [31:0]         rdata_buf;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic        mem_req;
    logic [1:0]  vaddr_lo;
    logic [4:0]  ld_type;
    logic        is_load;
    logic        owned;
    logic        ready_go;
    logic        leave;
    logic [31:0] ld_word;
    logic [31:0] result;

    assign mem_req  = bus_r[MEM_REQ_BIT];
    assign vaddr_lo = bus_r[VLO_HI:VLO_LO];
    assign ld_type  = bus_r[LD_HI:LD_LO];
    assign is_load  = |ld_type;

    // a response is ours only once every cancelled request has drained
    assign owned    = data_sram_data_ok && (cancel_cnt == '0);
    assign ready_go = !mem_req | buf_valid | owned;
    assign leave    = MEM_valid & ready_go & WB_allowin;

    assign MEM_allowin     = !MEM_valid | (ready_go & WB_allowin);
    assign MEM_to_WB_valid = MEM_valid & ready_go & ~exec_flush;

    always_ff @(posedge clk) begin
        if (reset || exec_flush)
            MEM_valid <= 1'b0;
        else if (MEM_allowin)
            MEM_valid <= EXE_to_MEM_valid;
    end

    always_ff @(posedge clk) begin
        if (MEM_allowin && EXE_to_MEM_valid)
            bus_r <= EXE_to_MEM_bus;
    end

    always_ff @(posedge clk) begin
        if (reset)
            buf_valid <= 1'b0;
        else if (exec_flush || leave)
            buf_valid <= 1'b0;
        else if (owned && MEM_valid && mem_req)
            buf_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (owned && MEM_valid && mem_req && !buf_valid)
            rdata_buf <= data_sram_rdata;
    end

    // outstanding responses to discard: MEM's own pending request (if
    // its data has not arrived) plus EXE's accepted one, netted
    // against a drop happening in the same cycle
    logic [CANCEL_W:0] cnt_inc;
    logic [CANCEL_W:0] cnt_dec;
    logic [CANCEL_W:0] cnt_sum;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        if (exec_flush)
            cnt_inc = (CANCEL_W+1)'(MEM_valid & mem_req & ~buf_valid & ~owned)
                    + (CANCEL_W+1)'(EXE_req_inflight);
        if (data_sram_data_ok && (cancel_cnt != '0))
            cnt_dec = (CANCEL_W+1)'(1);
        cnt_sum = {1'b0, cancel_cnt} + cnt_inc - cnt_dec;
        if (cnt_sum > CNT_MAX)
            cnt_sum = CNT_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cancel_cnt <= '0;
        else
            cancel_cnt <= cnt_sum[CANCEL_W-1:0];
    end

    assign ld_word = buf_valid ? rdata_buf : data_sram_rdata;

    load_extract u_ext (
        .ld_type    (ld_type),
        .vaddr_lo   (vaddr_lo),
        .rdata      (ld_word),
        .alu_result (bus_r[31:0]),
        .result     (result)
    );

    assign MEM_to_WB_bus = {bus_r[222:32], result};

    assign MEM_to_ID_bus = {
        MEM_valid & is_load & ~ready_go,
        MEM_valid & bus_r[GR_WE_BIT],
        bus_r[DEST_HI:DEST_LO],
        result
    };

    assign MEM_flush_hint = MEM_valid & has_flush(bus_r[222:0]);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Walks loads, buffering, flush cancellation and exception pass-through.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         EXE_to_MEM_valid;
    logic         MEM_allowin;
    logic [230:0] EXE_to_MEM_bus;
    logic         EXE_req_inflight;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         WB_allowin;
    logic         exec_flush;
    logic         MEM_to_WB_valid;
    logic [222:0] MEM_to_WB_bus;
    logic [38:0]  MEM_to_ID_bus;
    logic         MEM_flush_hint;

    int n_chk;
    int n_fail;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .EXE_to_MEM_valid  (EXE_to_MEM_valid),
        .MEM_allowin       (MEM_allowin),
        .EXE_to_MEM_bus    (EXE_to_MEM_bus),
        .EXE_req_inflight  (EXE_req_inflight),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .WB_allowin        (WB_allowin),
        .exec_flush        (exec_flush),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .MEM_to_WB_bus     (MEM_to_WB_bus),
        .MEM_to_ID_bus     (MEM_to_ID_bus),
        .MEM_flush_hint    (MEM_flush_hint)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [4:0] T_B  = 5'b10000;
    localparam logic [4:0] T_H  = 5'b01000;
    localparam logic [4:0] T_W  = 5'b00100;
    localparam logic [4:0] T_BU = 5'b00010;
    localparam logic [4:0] T_HU = 5'b00001;

    function automatic logic [230:0] mk_bus(
        input logic        mreq,
        input logic [1:0]  vlo,
        input logic [4:0]  ld,
        input logic [31:0] alu
    );
        logic [230:0] b;
        b = '0;
        b[230]     = mreq;
        b[229:228] = vlo;
        b[227:223] = ld;
        b[37]      = 1'b1;
        b[36:32]   = 5'd7;
        b[31:0]    = alu;
        return b;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [230:0] b);
        EXE_to_MEM_valid = 1'b1;
        EXE_to_MEM_bus   = b;
        tick();
        EXE_to_MEM_valid = 1'b0;
        #1;
    endtask

    task automatic load_once(
        input string       tag,
        input logic [230:0] b,
        input logic [31:0] rd,
        input logic [31:0] exp
    );
        issue(b);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({tag, "_v"}, 32'(MEM_to_WB_valid), 32'd1);
        chk({tag, "_d"}, MEM_to_WB_bus[31:0], exp);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
    endtask

    logic [230:0] exc_bus;

    initial begin
        n_chk             = 0;
        n_fail            = 0;
        reset             = 1'b1;
        EXE_to_MEM_valid  = 1'b0;
        EXE_to_MEM_bus    = '0;
        EXE_req_inflight  = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        WB_allowin        = 1'b1;
        exec_flush        = 1'b0;
        tick();
        tick();
        chk("rst_allowin", 32'(MEM_allowin), 32'd1);
        chk("rst_wbv", 32'(MEM_to_WB_valid), 32'd0);
        chk("rst_hint", 32'(MEM_flush_hint), 32'd0);
        chk("rst_blkwe", 32'(MEM_to_ID_bus[38:37]), 32'd0);
        chk("rst_cnt", 32'(dut.cancel_cnt), 32'd0);
        chk("rst_buf", 32'(dut.buf_valid), 32'd0);
        reset = 1'b0;
        #1;

        // ld.b waits, then same-cycle delivery
        issue(mk_bus(1'b1, 2'd2, T_B, 32'h0));
        chk("wait_wbv", 32'(MEM_to_WB_valid), 32'd0);
        chk("wait_blk", 32'(MEM_to_ID_bus[38]), 32'd1);
        chk("wait_we", 32'(MEM_to_ID_bus[37]), 32'd1);
        chk("wait_allowin", 32'(MEM_allowin), 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12F45678;
        #1;
        chk("ldb_v", 32'(MEM_to_WB_valid), 32'd1);
        chk("ldb_d", MEM_to_WB_bus[31:0], 32'hFFFFFFF4);
        chk("ldb_fwd", MEM_to_ID_bus[31:0], 32'hFFFFFFF4);
        chk("ldb_blk", 32'(MEM_to_ID_bus[38]), 32'd0);
        chk("ldb_dest", 32'(MEM_to_ID_bus[36:32]), 32'd7);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldb_gone", 32'(MEM_to_WB_valid), 32'd0);

        load_once("ldhu", mk_bus(1'b1, 2'd2, T_HU, 32'h0),
                  32'h80010000, 32'h00008001);
        load_once("ldh", mk_bus(1'b1, 2'd2, T_H, 32'h0),
                  32'h80010000, 32'hFFFF8001);
        load_once("ldbu", mk_bus(1'b1, 2'd3, T_BU, 32'h0),
                  32'h9A000000, 32'h0000009A);
        load_once("ldh0", mk_bus(1'b1, 2'd0, T_H, 32'h0),
                  32'h80017FFF, 32'h00007FFF);
        load_once("ldb1", mk_bus(1'b1, 2'd1, T_B, 32'h0),
                  32'h00008000, 32'hFFFFFF80);

        // non-load keeps the ALU result with no wait
        issue(mk_bus(1'b0, 2'd0, 5'b0, 32'hDEADBEEF));
        chk("alu_v", 32'(MEM_to_WB_valid), 32'd1);
        chk("alu_d", MEM_to_WB_bus[31:0], 32'hDEADBEEF);
        chk("alu_blk", 32'(MEM_to_ID_bus[38]), 32'd0);
        tick();

        // response with WB stalled goes into the buffer
        issue(mk_bus(1'b1, 2'd0, T_W, 32'h0));
        WB_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEBABE;
        #1;
        chk("buf_v0", 32'(MEM_to_WB_valid), 32'd1);
        chk("buf_allow0", 32'(MEM_allowin), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("buf_set", 32'(dut.buf_valid), 32'd1);
        chk("buf_d1", MEM_to_WB_bus[31:0], 32'hCAFEBABE);
        tick();
        tick();
        WB_allowin = 1'b1;
        #1;
        chk("buf_allow", 32'(MEM_allowin), 32'd1);
        chk("buf_v", 32'(MEM_to_WB_valid), 32'd1);
        chk("buf_d", MEM_to_WB_bus[31:0], 32'hCAFEBABE);
        tick();
        chk("buf_once", 32'(MEM_to_WB_valid), 32'd0);
        chk("buf_clr", 32'(dut.buf_valid), 32'd0);

        // flush with MEM waiting and EXE in flight: two drops
        issue(mk_bus(1'b1, 2'd0, T_W, 32'h0));
        exec_flush       = 1'b1;
        EXE_req_inflight = 1'b1;
        #1;
        chk("fl_wbv", 32'(MEM_to_WB_valid), 32'd0);
        tick();
        exec_flush       = 1'b0;
        EXE_req_inflight = 1'b0;
        #1;
        chk("fl_cnt2", 32'(dut.cancel_cnt), 32'd2);
        chk("fl_allow", 32'(MEM_allowin), 32'd1);
        issue(mk_bus(1'b1, 2'd0, T_W, 32'h0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11111111;
        #1;
        chk("drop1", 32'(MEM_to_WB_valid), 32'd0);
        tick();
        data_sram_rdata = 32'h22222222;
        #1;
        chk("drop2", 32'(MEM_to_WB_valid), 32'd0);
        chk("fl_cnt1", 32'(dut.cancel_cnt), 32'd1);
        tick();
        data_sram_rdata = 32'h33333333;
        #1;
        chk("fl_cnt0", 32'(dut.cancel_cnt), 32'd0);
        chk("own3_v", 32'(MEM_to_WB_valid), 32'd1);
        chk("own3_d", MEM_to_WB_bus[31:0], 32'h33333333);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("own3_once", 32'(MEM_to_WB_valid), 32'd0);

        // flush on the same cycle as MEM's own response
        issue(mk_bus(1'b1, 2'd0, T_W, 32'h0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h44444444;
        exec_flush        = 1'b1;
        EXE_req_inflight  = 1'b1;
        #1;
        chk("co_wbv", 32'(MEM_to_WB_valid), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        exec_flush        = 1'b0;
        EXE_req_inflight  = 1'b0;
        #1;
        chk("co_cnt1", 32'(dut.cancel_cnt), 32'd1);

        // drop nets against a new increment
        data_sram_data_ok = 1'b1;
        exec_flush        = 1'b1;
        EXE_req_inflight  = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        exec_flush        = 1'b0;
        EXE_req_inflight  = 1'b0;
        #1;
        chk("net_cnt1", 32'(dut.cancel_cnt), 32'd1);
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("net_cnt0", 32'(dut.cancel_cnt), 32'd0);
        load_once("after", mk_bus(1'b1, 2'd0, T_W, 32'h0),
                  32'h55555555, 32'h55555555);
        chk("after_once", 32'(MEM_to_WB_valid), 32'd0);

        // exception instruction: hint, no wait
        exc_bus          = mk_bus(1'b0, 2'd0, 5'b0, 32'h1234);
        exc_bus[INE_BIT] = 1'b1;
        issue(exc_bus);
        chk("exc_hint", 32'(MEM_flush_hint), 32'd1);
        chk("exc_v", 32'(MEM_to_WB_valid), 32'd1);
        chk("exc_blk", 32'(MEM_to_ID_bus[38]), 32'd0);
        chk("exc_allow", 32'(MEM_allowin), 32'd1);
        tick();
        chk("exc_left", 32'(MEM_flush_hint), 32'd0);

        // reset mid-wait abandons everything
        issue(mk_bus(1'b1, 2'd0, T_W, 32'h0));
        EXE_req_inflight = 1'b1;
        reset            = 1'b1;
        tick();
        reset            = 1'b0;
        EXE_req_inflight = 1'b0;
        #1;
        chk("rw_cnt", 32'(dut.cancel_cnt), 32'd0);
        chk("rw_allow", 32'(MEM_allowin), 32'd1);
        chk("rw_wbv", 32'(MEM_to_WB_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
